// File: rtl/audio_pkg.sv
// Shared audio definitions: clock-derived defaults, player FSM states, PWM midpoint helpers.
// No logic; constants and types only.
// No handshaking.
package audio_pkg;

    localparam int SYSTEM_FREQ  = 100_000_000;
    localparam int AUDIO_MS_DIV = SYSTEM_FREQ / 1000;
    localparam int AUDIO_PWM_W  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } play_state_t;

    localparam int PWM_MID = 1 << (AUDIO_PWM_W - 1);

    function automatic int pwm_mid(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/pwm_serializer.sv
// Free-running PWM: out is high while the counter is below duty.
// Latency: one register from duty/enable to out.
// Backpressure: none; out is forced low the cycle after enable drops.
module pwm_serializer #(
    parameter int PWM_W = 10
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic [PWM_W-1:0] duty,
    output logic             out
);

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt <= '0;
            out     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            out     <= enable && (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/tone_player.sv
// Plays one note from a programmable half-period table for duration_ms milliseconds at a set volume.
// Latency: busy one cycle after start; done one cycle after the final millisecond tick.
// Backpressure: start while busy is dropped; stop aborts the note without a done pulse.
module tone_player
    import audio_pkg::*;
#(
    parameter int NUM_TONES = 4,
    parameter int TONE_W    = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1,
    parameter int HALF_W    = 18,
    parameter int DUR_W     = 16,
    parameter int PWM_W     = AUDIO_PWM_W,
    parameter int MS_DIV    = AUDIO_MS_DIV
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cfg_we,
    input  logic [TONE_W-1:0] cfg_addr,
    input  logic [HALF_W-1:0] cfg_half,
    input  logic              start,
    input  logic [TONE_W-1:0] tone_sel,
    input  logic [DUR_W-1:0]  duration_ms,
    input  logic [PWM_W-2:0]  volume,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              audioEn,
    output logic              audioOut
);

    localparam int MS_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [MS_W-1:0]  MS_LAST = MS_W'(MS_DIV - 1);
    localparam logic [PWM_W-1:0] MID     = PWM_W'(pwm_mid(PWM_W));

    logic [HALF_W-1:0] tone_tbl [NUM_TONES];

    play_state_t       state;
    logic [HALF_W-1:0] half_q;
    logic [DUR_W-1:0]  rem_ms;
    logic [PWM_W-2:0]  vol_q;
    logic [HALF_W-1:0] tone_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic              phase;
    logic [HALF_W-1:0] sel_half;
    logic [PWM_W-1:0]  duty;
    logic              pwm_out;
    logic              ms_tick;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_TONES; i++) tone_tbl[i] <= '0;
        end else if (cfg_we && (int'(cfg_addr) < NUM_TONES)) begin
            tone_tbl[cfg_addr] <= cfg_half;
        end
    end

    // Out-of-range selects play as a rest rather than reading past the table.
    assign sel_half = (int'(tone_sel) < NUM_TONES) ? tone_tbl[tone_sel] : '0;
    assign ms_tick  = (ms_cnt == MS_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            half_q   <= '0;
            rem_ms   <= '0;
            vol_q    <= '0;
            tone_cnt <= '0;
            ms_cnt   <= '0;
            phase    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            audioEn  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (duration_ms != '0) begin
                            state    <= PLAY;
                            busy     <= 1'b1;
                            audioEn  <= 1'b1;
                            half_q   <= sel_half;
                            rem_ms   <= duration_ms;
                            vol_q    <= volume;
                            tone_cnt <= '0;
                            ms_cnt   <= '0;
                            phase    <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        audioEn <= 1'b0;
                    end else begin
                        if (half_q == '0) begin
                            tone_cnt <= '0;
                            phase    <= 1'b0;
                        end else if (tone_cnt == half_q) begin
                            tone_cnt <= '0;
                            phase    <= ~phase;
                        end else begin
                            tone_cnt <= tone_cnt + 1'b1;
                        end

                        if (ms_tick) begin
                            ms_cnt <= '0;
                            rem_ms <= rem_ms - 1'b1;
                            if (rem_ms == DUR_W'(1)) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                audioEn <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        duty = MID;
        if (state == PLAY && half_q != '0) begin
            duty = phase ? (MID + {1'b0, vol_q}) : (MID - {1'b0, vol_q});
        end
    end

    pwm_serializer #(.PWM_W(PWM_W)) u_pwm (
        .clock  (clock),
        .resetn (resetn),
        .enable (audioEn),
        .duty   (duty),
        .out    (pwm_out)
    );

    // The serializer register lags the enable by a cycle, so gate with the live enable.
    assign audioOut = pwm_out & audioEn;

endmodule

// File: tb/tb_tone_player.sv
// Bench for tone_player: directed scenarios plus random traffic against a note-level reference model.
module tb_tone_player;

    localparam int M    = 10;
    localparam int MIDV = 512;

    logic        clock;
    logic        resetn;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [17:0] cfg_half;
    logic        start;
    logic [1:0]  tone_sel;
    logic [15:0] duration_ms;
    logic [8:0]  volume;
    logic        stop;
    logic        busy, done, audioEn, audioOut;

    tone_player #(.NUM_TONES(4), .HALF_W(18), .DUR_W(16), .PWM_W(10), .MS_DIV(M)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_half    (cfg_half),
        .start       (start),
        .tone_sel    (tone_sel),
        .duration_ms (duration_ms),
        .volume      (volume),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .audioEn     (audioEn),
        .audioOut    (audioOut)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a note is described by cycles elapsed since it started.
    int m_tbl [4];
    bit m_play;
    int m_n, m_dlen, m_half, m_vol, m_pwm;
    bit e_busy, e_done, e_out;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) m_tbl[i] = 0;
            m_play = 0; m_n = 0; m_dlen = 0; m_half = 0; m_vol = 0; m_pwm = 0;
            e_busy = 0; e_done = 0; e_out = 0;
        end else begin
            int duty_cur;
            bit was_play;
            was_play = m_play;
            duty_cur = MIDV;
            if (m_play && m_half != 0)
                duty_cur = (((m_n / (m_half + 1)) % 2) == 0) ? MIDV + m_vol : MIDV - m_vol;
            e_done = 0;
            if (m_play) begin
                if (stop) m_play = 0;
                else if (m_n + 1 == m_dlen) begin m_play = 0; e_done = 1; end
                else m_n++;
            end else if (start) begin
                if (duration_ms == 0) e_done = 1;
                else begin
                    m_play = 1; m_n = 0; m_dlen = int'(duration_ms) * M;
                    m_half = m_tbl[tone_sel]; m_vol = int'(volume);
                end
            end
            if (cfg_we) m_tbl[cfg_addr] = int'(cfg_half);
            e_out  = was_play && m_play && (m_pwm < duty_cur);
            m_pwm  = (m_pwm + 1) % 1024;
            e_busy = m_play;
        end
    end

    bit chk_en = 0;
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(e_busy));
            check("done", int'(done), int'(e_done));
            check("audioEn", int'(audioEn), int'(e_busy));
            check("audioOut", int'(audioOut), int'(e_out));
            check("done_with_busy", int'(busy & done), 0);
        end
    end

    task automatic clear_inputs();
        cfg_we = 0; cfg_addr = 0; cfg_half = 0; start = 0;
        tone_sel = 0; duration_ms = 0; volume = 0; stop = 0;
    endtask

    task automatic wcfg(input int addr, input int half);
        cfg_we = 1; cfg_addr = 2'(addr); cfg_half = 18'(half);
        @(negedge clock);
        cfg_we = 0;
    endtask

    // Returns at the first negedge after the start edge (k = 1).
    task automatic do_start(input int sel, input int dur, input int vol);
        start = 1; tone_sel = 2'(sel); duration_ms = 16'(dur); volume = 9'(vol);
        @(negedge clock);
        start = 0;
    endtask

    task automatic wait_done(input int k0, input int lim, output int k);
        k = k0;
        while (!done && k < lim) begin
            @(negedge clock);
            k++;
        end
        if (!done) k = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, dcnt;
        clear_inputs();
        resetn = 0;
        repeat (3) @(negedge clock);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_audioEn", int'(audioEn), 0);
        check("reset_audioOut", int'(audioOut), 0);
        resetn = 1;
        chk_en = 1;
        @(negedge clock);

        // Basic note: half=4 toggles every 5 clocks, 3 ms = 30 clocks.
        wcfg(2, 4);
        check("pre_start_busy", int'(busy), 0);
        do_start(2, 3, 100);
        check("start_busy", int'(busy), 1);
        check("duty_high", int'(dut.duty), 612);
        dcnt = 0; k = 1;
        for (int i = 2; i <= 45; i++) begin
            @(negedge clock);
            if (i == 6) check("duty_low", int'(dut.duty), 412);
            if (done) begin dcnt++; k = i; end
        end
        check("note_done_cycle", k, 31);
        check("note_done_count", dcnt, 1);

        // Zero duration.
        do_start(0, 0, 50);
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        check("zero_out", int'(audioOut), 0);
        @(negedge clock);
        check("zero_done_single", int'(done), 0);

        // Rest note.
        wcfg(1, 0);
        do_start(1, 2, 200);
        check("rest_duty0", int'(dut.duty), 512);
        repeat (6) @(negedge clock);
        check("rest_duty6", int'(dut.duty), 512);
        wait_done(7, 40, k);
        check("rest_done_cycle", k, 21);
        @(negedge clock);

        // Abort with an ignored start during busy.
        do_start(2, 5, 300);
        dcnt = 0;
        for (int i = 2; i <= 12; i++) begin
            @(negedge clock);
            start = 0; stop = 0;
            if (done) dcnt++;
            if (i == 3) begin start = 1; tone_sel = 1; duration_ms = 0; end
            if (i == 12) begin
                check("abort_busy_before_stop", int'(busy), 1);
                stop = 1;
            end
        end
        @(negedge clock);
        stop = 0;
        check("abort_busy", int'(busy), 0);
        check("abort_en", int'(audioEn), 0);
        for (int i = 0; i < 60; i++) begin
            if (done) dcnt++;
            @(negedge clock);
        end
        check("abort_no_done", dcnt, 0);

        // Stop on the final-tick cycle.
        do_start(2, 1, 10);
        for (int i = 2; i <= 10; i++) begin
            @(negedge clock);
            if (i == 10) stop = 1;
        end
        @(negedge clock);
        stop = 0;
        check("coinc_busy", int'(busy), 0);
        check("coinc_done", int'(done), 0);
        dcnt = 0;
        repeat (5) begin @(negedge clock); if (done) dcnt++; end
        check("coinc_no_done", dcnt, 0);

        // Table rewrite mid-note only affects the next start.
        do_start(2, 2, 100);
        for (int i = 2; i <= 6; i++) begin
            @(negedge clock);
            cfg_we = 0;
            if (i == 3) begin cfg_we = 1; cfg_addr = 2; cfg_half = 9; end
            if (i == 6) check("midwrite_old_half", int'(dut.duty), 412);
        end
        wait_done(6, 40, k);
        check("midwrite_done1", k, 21);
        @(negedge clock);
        do_start(2, 2, 100);
        check("newhalf_k1", int'(dut.duty), 612);
        repeat (5) @(negedge clock);
        check("newhalf_k6", int'(dut.duty), 612);
        repeat (5) @(negedge clock);
        check("newhalf_k11", int'(dut.duty), 412);
        wait_done(11, 40, k);
        check("newhalf_done", k, 21);
        @(negedge clock);

        // Asynchronous reset between edges during a note.
        do_start(2, 3, 100);
        repeat (6) @(negedge clock);
        #2 resetn = 0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_en", int'(audioEn), 0);
        check("arst_out", int'(audioOut), 0);
        check("arst_done", int'(done), 0);
        @(negedge clock);
        resetn = 1;
        @(negedge clock);
        do_start(2, 1, 100);
        check("arst_tbl_rest", int'(dut.duty), 512);
        wait_done(1, 30, k);
        check("arst_done_cycle", k, 11);
        @(negedge clock);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom % 8) == 0;
            tone_sel    = 2'($urandom % 4);
            duration_ms = 16'($urandom % 4);
            volume      = 9'($urandom % 512);
            stop        = ($urandom % 40) == 0;
            cfg_we      = ($urandom % 16) == 0;
            cfg_addr    = 2'($urandom % 4);
            cfg_half    = 18'($urandom % 7);
            @(negedge clock);
        end
        clear_inputs();
        repeat (50) @(negedge clock);
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Parametrised successor of the single-tone audio block: plays one note at a time, chosen from a software-programmable table of NUM_TONES entries, for a commanded duration in milliseconds, at a selectable volume.
- Reports busy/done to the game controller so note sequences can be chained without CPU timing loops.
- Drives the board audio amplifier through an internal PWM serializer.
- Sits between the game-logic MMIO and the audio pins.

Parameters:
- NUM_TONES, 4, number of frequency-table entries.
- TONE_W, $clog2(NUM_TONES), tone select width.
- HALF_W, 18, width of half-period count (clocks per half audio period minus 1).
- DUR_W, 16, duration width, units of 1 ms.
- PWM_W, 10, PWM resolution; volume is PWM_W-1 bits.
- MS_DIV, 100000, clocks per millisecond tick (100 MHz system clock).

Ports:
- clock, in, 1, system clock.
- resetn, in, 1, asynchronous active-low reset.
- cfg_we, in, 1, table write strobe.
- cfg_addr, in, TONE_W, table entry to write.
- cfg_half, in, HALF_W, half-period count; 0 means rest (silence).
- start, in, 1, single-cycle play request.
- tone_sel, in, TONE_W, entry to play.
- duration_ms, in, DUR_W, note length.
- volume, in, PWM_W-1, deviation from duty midpoint.
- stop, in, 1, abort current note.
- busy, out, 1, note in progress.
- done, out, 1, one-cycle pulse on natural note completion.
- audioEn, out, 1, amplifier enable.
- audioOut, out, 1, PWM audio stream.

Behaviour:
- Reset (async, resetn=0): every table entry = 0; FSM = IDLE; busy = 0, done = 0, audioEn = 0, audioOut = 0; all counters = 0.
- Table: written on cfg_we at the clock edge; a write is legal in any state. The playing note uses the value latched at start, so rewriting the active entry has no effect until the next start.
- FSM states: IDLE, PLAY.
- IDLE + start, duration_ms != 0:
  - Latch table[tone_sel], duration_ms and volume.
  - Clear the tone counter, ms prescaler and square phase (phase = high).
  - Next cycle: state = PLAY, busy = 1, audioEn = 1.
- IDLE + start, duration_ms == 0: remain IDLE; done = 1 on the next cycle; busy stays 0.
- start while busy: ignored, no latch.
- PLAY, tone counter:
  - Counts 0..half_latched. On reaching half_latched it wraps to 0 and the square phase toggles.
  - If half_latched == 0 (rest), the phase is held low and the duty is forced to the midpoint.
- PLAY, duration timer:
  - The prescaler counts 0..MS_DIV-1 and issues a 1-cycle tick on wrap.
  - Each tick decrements remaining_ms.
  - A tick with remaining_ms == 1 moves the FSM to IDLE and sets done = 1 on the following cycle.
  - busy = 0 and audioEn = 0 in that same cycle.
  - Note length = duration_ms*MS_DIV clocks (plus or minus 1).
- stop in PLAY: IDLE next cycle, no done pulse. If stop and the final tick coincide, stop wins and there is no done. stop in IDLE is ignored.
- Duty (PWM_W bits), with MID = 2^(PWM_W-1):
  - Phase high: duty = MID + volume.
  - Phase low: duty = MID - volume.
  - IDLE or rest: duty = MID.
- PWM: free-running PWM_W-bit counter; audioOut = (pwm_cnt < duty), registered. audioOut stays 0 whenever audioEn = 0.
- done is a single-cycle pulse and is never asserted together with busy.

Decomposition:
- Shared package audio_pkg:
  - Defaults: SYSTEM_FREQ, MS_DIV, PWM_W.
  - FSM state enum (IDLE, PLAY).
  - Helper constant PWM_MID.
- One sub-module, pwm_serializer (parameter PWM_W; ports clock, resetn, enable, duty, out), reused by later audio blocks.

Test Plan (MS_DIV=10, HALF_W=18, PWM_W=10):
- Reset, write table[2]=4, start tone 2, dur 3, vol 100:
  - busy rises 1 cycle after start.
  - Square phase toggles every 5 clocks.
  - Duty alternates 612/412.
  - done pulses once, about 30 clocks after start, with busy=0 on that cycle.
- start with duration_ms=0: done=1 exactly one cycle later, busy never 1, audioOut stays 0.
- Rest: table[1]=0, play tone 1, dur 2: busy for about 20 clocks, duty held at 512, done pulses.
- Abort: start dur 5, assert stop at clock 12: busy=0 next cycle, audioEn=0, no done for 60 clocks. A second start issued during busy earlier is shown ignored.
- Coincidence and mid-note writes:
  - Assert stop on the final-tick cycle: no done.
  - Write table[2]=9 mid-note: half-period stays 4 until the next start, then 9.
- Async reset mid-PLAY (resetn low between edges): outputs 0 immediately. After release, table[2] reads back 0 (silent rest when played).
